// File: rtl/result_sequencer.sv
// Presents a captured 32-bit adder result one byte at a time, stepped by a
// locked "next" button or, optionally, by a dwell timer.
module result_sequencer #(
    parameter int AUTO_MODE = 0,
    parameter int DWELL     = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sum,
    input  logic        cin_carry,
    input  logic        capture,
    input  logic        next,
    input  logic        unlock,
    output logic [7:0]  out,
    output logic [1:0]  byte_idx,
    output logic        valid,
    output logic        coutled,
    output logic        doneled,
    output logic        lockled
);

    localparam int             CNT_W    = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam bit             AUTO_EN  = (AUTO_MODE != 0);

    typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      hold_q, hold_d;
    logic             carry_q, carry_d;
    logic             lock_q, lock_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       out_q, out_d;
    logic             valid_q, valid_d;
    logic             accept, expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            carry_q <= 1'b0;
            lock_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            carry_q <= carry_d;
            lock_q  <= lock_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        carry_d = carry_q;
        lock_d  = lock_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        accept  = next && !lock_q;
        expire  = AUTO_EN && (state_q == SHOW) && (cnt_q == CNT_LAST);

        if (capture) begin
            // Capture wins outright: the lock is deliberately left untouched.
            hold_d  = sum;
            carry_d = cin_carry;
            state_d = SHOW;
            idx_d   = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            if (accept)
                lock_d = 1'b1;
            else if (unlock)
                lock_d = 1'b0;

            case (state_q)
                SHOW: begin
                    // A simultaneous button press and timer expiry is one advance.
                    if (accept || expire) begin
                        cnt_d = '0;
                        if (idx_q == 2'd3) begin
                            state_d = DONE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else if (AUTO_EN) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end

        valid_d = (state_d == SHOW);
        out_d   = '0;
        if (state_d == SHOW) begin
            case (idx_d)
                2'd0:    out_d = hold_d[7:0];
                2'd1:    out_d = hold_d[15:8];
                2'd2:    out_d = hold_d[23:16];
                default: out_d = hold_d[31:24];
            endcase
        end
    end

    assign out      = out_q;
    assign byte_idx = idx_q;
    assign valid    = valid_q;
    assign coutled  = carry_q;
    assign doneled  = done_q;
    assign lockled  = lock_q;

endmodule
